pc_fetch_ctrl: RTL
==================

# pc_fetch_ctrl

Parametrised program-counter and instruction-fetch request generator for the front end of the pipeline. It issues fetch addresses to instruction memory over a req/ack handshake and honours the pipeline stall vector. Branch and exception redirects are latched so that none is lost while stalled or waiting on memory. Exceptions take priority over branches. The `pc_o` and `ram_op_o` outputs feed the IF/ID stage.

## Interface
Parameters:
- `ADDR_W`, 32: address width.
- `RESET_VECTOR`, 32'hBFC0_0000: first fetch address after reset.
- `EXC_VECTOR`, 32'hBFC0_0380: redirect target for misaligned-target faults (see Configuration).
- `STALL_W`, 6: stall vector width. Only bit 0 is used.

Ports:
- `clk` in 1: clock, rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `stall_i` in STALL_W: pipeline stall vector. Bit 0 freezes fetch issue.
- `branch_en_i` in 1: branch redirect pulse.
- `branch_addr_i` in ADDR_W: branch target.
- `exc_en_i` in 1: exception/eret redirect pulse.
- `exc_addr_i` in ADDR_W: exception/eret target.
- `fetch_req_o` out 1: fetch request, registered.
- `fetch_addr_o` out ADDR_W: fetch address, registered.
- `fetch_ack_i` in 1: memory accepts the request this cycle.
- `pc_o` out ADDR_W: address of the last accepted fetch.
- `pc_valid_o` out 1: one-cycle pulse when `pc_o` updates.
- `ram_op_o` out 4: 4'b1000 while `fetch_req_o`=1, else 4'b0000.
- `redirect_pending_o` out 1: a latched redirect is not yet applied.
- `adel_o` out 1: misaligned-target fault pulse.
- `badaddr_o` out ADDR_W: faulting target.

## Operation
- FSM states:
  - IDLE: `fetch_req_o`=0.
  - ISSUE: `fetch_req_o`=1, `fetch_addr_o` = `next_pc`.
- IDLE → ISSUE at an edge where `stall_i[0]`=0. IDLE holds while `stall_i[0]`=1.
- In ISSUE, the request is held with `fetch_addr_o` stable until `fetch_ack_i`=1. `stall_i` is ignored while waiting.
- On acceptance (ISSUE with ack=1):
  - `pc_o` ← `fetch_addr_o`; `pc_valid_o` pulses.
  - `next_pc` ← pending redirect target if one exists (pending cleared), else `fetch_addr_o`+4. The add wraps modulo 2^ADDR_W.
  - Next state is ISSUE if `stall_i[0]`=0 (back-to-back fetch), else IDLE.
- Redirect latch:
  - A branch or exception pulse sets pending, with the target and its source.
  - `exc_en_i` and `branch_en_i` in the same cycle: the exception wins.
  - A branch arriving while an exception is pending is dropped.
  - An exception arriving while a branch is pending replaces it.
  - A newer redirect of the same class overwrites the older one.
- Applying a redirect:
  - In IDLE, pending is applied to `next_pc` at the next edge, stalled or not.
  - A redirect arriving in the acceptance cycle is applied to that acceptance's `next_pc` directly.
  - An in-flight request address is never altered. The wrong-path fetch completes, which covers the delay slot.
- `rst` mid-transaction abandons the request. Memory must tolerate a dropped req.

## Timing
- Reset values:
  - `fetch_req_o`=0, `fetch_addr_o`=RESET_VECTOR.
  - `pc_o`=0, `pc_valid_o`=0, `ram_op_o`=0.
  - `redirect_pending_o`=0, `adel_o`=0, `badaddr_o`=0.
  - State IDLE, `next_pc`=RESET_VECTOR.
- First edge with `rst`=0 and `stall_i[0]`=0: `fetch_req_o`=1 with RESET_VECTOR visible after that edge.
- With ack tied to 1 and no stall, throughput is one fetch per cycle.
- `pc_o` lags acceptance by one edge.
- A redirect seen at edge n while in ISSUE and unacked takes effect on the address issued after that request's ack.
- `redirect_pending_o` is registered. It is high from the edge after the pulse until the edge that applies it.

## Configuration
- `PC_ALIGN_CHECK_EN` defined:
  - When applied, a redirect target with [1:0]≠0 loads `next_pc` ← EXC_VECTOR.
  - `adel_o` pulses one cycle and `badaddr_o` ← the target, both at that same edge.
- `PC_ALIGN_CHECK_EN` undefined:
  - Target[1:0] is forced to 2'b00.
  - `adel_o` and `badaddr_o` are tied to 0. The ports remain.

## Test plan
- Reset, then `rst`=0 with ack=1 and no stall → `fetch_addr_o` = BFC00000, BFC00004, BFC00008 on consecutive cycles; `pc_valid_o` pulses one edge after each.
- ack held 0 for 3 cycles with `stall_i`=6'h01 asserted mid-wait → `fetch_req_o` and `fetch_addr_o` stay stable; after ack, FSM goes to IDLE, `ram_op_o`=0.
- `branch_en_i` with target 0x80001000 during an unacked request → current address completes, next issued address is 0x80001000, `redirect_pending_o` is high in between.
- `exc_en_i` (0x80000180) and `branch_en_i` (0x80002000) in the same cycle → next address 0x80000180. A branch pulse one cycle later is dropped.
- Redirect while stalled in IDLE for 5 cycles → after the stall releases, the first issued address is the target.
- With `PC_ALIGN_CHECK_EN`: branch target 0x80000002 → next address BFC00380, `adel_o` pulse, `badaddr_o`=0x80000002. Without the macro → next address 0x80000000.

Source files
------------

// File: rtl/pc_fetch_ctrl.sv
// pc_fetch_ctrl: program counter and instruction-fetch request generator.
// Issues fetch addresses over a req/ack handshake, honours stall_i[0], and
// latches branch/exception redirects so none is lost while stalled or waiting.
// Optional feature macro: PC_ALIGN_CHECK_EN (misaligned redirect target fault).
//
// Handshake: fetch_req_o/fetch_addr_o form a valid/ready pair with
// fetch_ack_i as ready. Once fetch_req_o is raised, it and fetch_addr_o hold
// unchanged until the cycle fetch_ack_i is sampled high. Only the
// synchronous reset withdraws a request without an ack.
module pc_fetch_ctrl #(
  parameter int                 ADDR_W       = 32,
  parameter logic [ADDR_W-1:0]  RESET_VECTOR = 32'hBFC0_0000,
  parameter logic [ADDR_W-1:0]  EXC_VECTOR   = 32'hBFC0_0380,
  parameter int                 STALL_W      = 6
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [STALL_W-1:0]  stall_i,
  input  logic                branch_en_i,
  input  logic [ADDR_W-1:0]   branch_addr_i,
  input  logic                exc_en_i,
  input  logic [ADDR_W-1:0]   exc_addr_i,
  output logic                fetch_req_o,
  output logic [ADDR_W-1:0]   fetch_addr_o,
  input  logic                fetch_ack_i,
  output logic [ADDR_W-1:0]   pc_o,
  output logic                pc_valid_o,
  output logic [3:0]          ram_op_o,
  output logic                redirect_pending_o,
  output logic                adel_o,
  output logic [ADDR_W-1:0]   badaddr_o,
  output logic                dbg_state_o
);

  typedef enum logic {S_IDLE = 1'b0, S_ISSUE = 1'b1} state_t;

  state_t             r_state, w_state_nxt;
  logic               r_fetch_req, w_req_nxt;
  logic [ADDR_W-1:0]  r_fetch_addr, w_addr_nxt;
  logic [ADDR_W-1:0]  r_next_pc, w_next_pc_nxt;
  logic [ADDR_W-1:0]  r_pc, w_pc_nxt;
  logic               r_pc_valid, w_pcv_nxt;
  logic               r_pend, w_pend_nxt;
  logic               r_pend_exc, w_pend_exc_nxt;
  logic [ADDR_W-1:0]  r_pend_addr, w_pend_addr_nxt;

  // Incoming redirect this cycle; an exception beats a simultaneous branch.
  logic               w_in_valid;
  logic [ADDR_W-1:0]  w_in_addr;
  // Pending redirect merged with the incoming one by class priority.
  logic               w_in_take;
  logic               w_mrg_valid;
  logic               w_mrg_exc;
  logic [ADDR_W-1:0]  w_mrg_addr;
  // Redirect target being applied this cycle and its resolved pc.
  logic               w_acc;
  logic [ADDR_W-1:0]  w_apply_tgt;
  logic [ADDR_W-1:0]  w_res_pc;
  logic               w_unused_stall;

  assign w_unused_stall = ^stall_i;

  assign w_in_valid  = exc_en_i | branch_en_i;
  assign w_in_addr   = exc_en_i ? exc_addr_i : branch_addr_i;
  // A branch cannot displace a pending exception; anything else newer wins.
  assign w_in_take   = exc_en_i | (branch_en_i & ~(r_pend & r_pend_exc));
  assign w_mrg_valid = r_pend | w_in_take;
  assign w_mrg_exc   = w_in_take ? exc_en_i : r_pend_exc;
  assign w_mrg_addr  = w_in_take ? w_in_addr : r_pend_addr;

  assign w_acc       = (r_state == S_ISSUE) & fetch_ack_i;
  // On acceptance the incoming pulse is folded in directly; in IDLE only the
  // already-latched redirect is applied.
  assign w_apply_tgt = w_acc ? w_mrg_addr : r_pend_addr;

`ifdef PC_ALIGN_CHECK_EN
  logic w_apply_valid;
  logic w_fault;
  logic r_adel;
  logic [ADDR_W-1:0] r_badaddr;

  assign w_apply_valid = w_acc ? w_mrg_valid : ((r_state == S_IDLE) & r_pend);
  assign w_fault       = w_apply_valid & (w_apply_tgt[1:0] != 2'b00);
  assign w_res_pc      = (w_apply_tgt[1:0] != 2'b00) ? EXC_VECTOR : w_apply_tgt;

  // Fault pulse and faulting target, captured at the edge that applies it.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_adel    <= 1'b0;
      r_badaddr <= '0;
    end else begin
      r_adel <= w_fault;
      if (w_fault) r_badaddr <= w_apply_tgt;
    end
  end

  assign adel_o    = r_adel;
  assign badaddr_o = r_badaddr;
`else
  logic w_unused_tgt_bits;
  assign w_unused_tgt_bits = ^w_apply_tgt[1:0];
  assign w_res_pc  = {w_apply_tgt[ADDR_W-1:2], 2'b00};
  assign adel_o    = 1'b0;
  assign badaddr_o = '0;
`endif

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_fetch_req  <= 1'b0;
      r_fetch_addr <= RESET_VECTOR;
      r_next_pc    <= RESET_VECTOR;
      r_pc         <= '0;
      r_pc_valid   <= 1'b0;
      r_pend       <= 1'b0;
      r_pend_exc   <= 1'b0;
      r_pend_addr  <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_fetch_req  <= w_req_nxt;
      r_fetch_addr <= w_addr_nxt;
      r_next_pc    <= w_next_pc_nxt;
      r_pc         <= w_pc_nxt;
      r_pc_valid   <= w_pcv_nxt;
      r_pend       <= w_pend_nxt;
      r_pend_exc   <= w_pend_exc_nxt;
      r_pend_addr  <= w_pend_addr_nxt;
    end
  end

  // Next-state, fetch issue, pc update and redirect latch bookkeeping.
  always_comb begin
    w_state_nxt     = r_state;
    w_req_nxt       = r_fetch_req;
    w_addr_nxt      = r_fetch_addr;
    w_next_pc_nxt   = r_next_pc;
    w_pc_nxt        = r_pc;
    w_pcv_nxt       = 1'b0;
    w_pend_nxt      = r_pend;
    w_pend_exc_nxt  = r_pend_exc;
    w_pend_addr_nxt = r_pend_addr;
    case (r_state)
      S_IDLE: begin
        if (r_pend) w_next_pc_nxt = w_res_pc;
        // Latched redirect is consumed; only a fresh pulse stays pending.
        w_pend_nxt     = w_in_valid;
        w_pend_exc_nxt = exc_en_i;
        if (w_in_valid) w_pend_addr_nxt = w_in_addr;
        if (!stall_i[0]) begin
          w_state_nxt = S_ISSUE;
          w_req_nxt   = 1'b1;
          w_addr_nxt  = r_pend ? w_res_pc : r_next_pc;
        end
      end
      S_ISSUE: begin
        if (fetch_ack_i) begin
          w_pc_nxt      = r_fetch_addr;
          w_pcv_nxt     = 1'b1;
          w_next_pc_nxt = w_mrg_valid ? w_res_pc : r_fetch_addr + ADDR_W'(4);
          w_pend_nxt    = 1'b0;
          if (stall_i[0]) begin
            w_state_nxt = S_IDLE;
            w_req_nxt   = 1'b0;
          end else begin
            w_addr_nxt  = w_next_pc_nxt;
          end
        end else begin
          w_pend_nxt      = w_mrg_valid;
          w_pend_exc_nxt  = w_mrg_exc;
          w_pend_addr_nxt = w_mrg_addr;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_req_nxt   = 1'b0;
      end
    endcase
  end

  assign fetch_req_o        = r_fetch_req;
  assign fetch_addr_o       = r_fetch_addr;
  assign pc_o               = r_pc;
  assign pc_valid_o         = r_pc_valid;
  assign ram_op_o           = r_fetch_req ? 4'b1000 : 4'b0000;
  assign redirect_pending_o = r_pend;
  assign dbg_state_o        = (r_state == S_ISSUE);

endmodule
